// File: rtl/row_scanout_if.sv
// Drawer write port and video output bundle for row_scanout.
// The master side is the drawer/display sink; the slave side is row_scanout.
interface row_scanout_if;
  logic [8:0]  address_write_row;
  logic [23:0] data_write_row;
  logic        wren;
  logic        swap;
  logic [23:0] pixel_rgb;
  logic        de;
  logic        hsync;
  logic        vsync;

  modport master (
    output address_write_row, data_write_row, wren,
    input  swap, pixel_rgb, de, hsync, vsync
  );

  modport slave (
    input  address_write_row, data_write_row, wren,
    output swap, pixel_rgb, de, hsync, vsync
  );
endinterface

// File: rtl/row_scanout.sv
// Ping-pong 512x24 row buffers with VGA timing; scans the front buffer and clears it behind the beam.
// Optional grid overlay on background pixels: define ROW_SCANOUT_GRID_EN.
module row_scanout #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          IMG_W    = 480,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic         clk,
  input  logic         rst_n,
  row_scanout_if.slave bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_IMG  = HW'(IMG_W);
  localparam logic [HW-1:0] H_BUF  = HW'(512);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT1 = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [23:0]   GRID_COLOR = 24'h404040;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          sel_q;
  logic          swap_w;

  always_comb begin
    h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
  end

  // Last visible line gets no swap so the 480 rows fit between the V_TOTAL-1 and V_ACTIVE-2 swaps.
  assign swap_w   = (h_cnt_q == H_ACT) && ((v_cnt_q < V_ACT1) || (v_cnt_q == V_LAST));
  assign bus.swap = swap_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= V_LAST;
      sel_q   <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      if (swap_w) sel_q <= ~sel_q;
    end
  end

  // Stage 1: read issued at h_cnt, clear of that address follows one cycle later.
  logic       clr_q;
  logic [8:0] clr_addr_q;
  logic       rd_sel_q;
  logic       img1_q, grid1_q;
  logic [1:0] de_pipe_q, hs_pipe_q, vs_pipe_q;
  logic       grid_w;

`ifdef ROW_SCANOUT_GRID_EN
  assign grid_w = ((int'(h_cnt_q) % 48) == 0) || ((int'(v_cnt_q) % 48) == 0);
`else
  assign grid_w = 1'b0;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_buf
    logic [23:0] mem [512] = '{default: BG_COLOR};
    logic [23:0] rd_q;
    logic        we;
    logic [8:0]  wa;
    logic [23:0] wd;
    logic        is_front;

    assign is_front = (sel_q == 1'(b));
    assign we = is_front ? clr_q      : bus.wren;
    assign wa = is_front ? clr_addr_q : bus.address_write_row;
    assign wd = is_front ? BG_COLOR   : bus.data_write_row;

    always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
      rd_q <= mem[h_cnt_q[8:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_q        <= 1'b0;
      clr_addr_q   <= '0;
      rd_sel_q     <= 1'b0;
      img1_q       <= 1'b0;
      grid1_q      <= 1'b0;
      de_pipe_q[0] <= 1'b0;
      hs_pipe_q[0] <= 1'b1;
      vs_pipe_q[0] <= 1'b1;
    end else begin
      clr_q        <= (h_cnt_q < H_BUF);
      clr_addr_q   <= h_cnt_q[8:0];
      rd_sel_q     <= sel_q;
      img1_q       <= (h_cnt_q < H_IMG);
      grid1_q      <= grid_w;
      de_pipe_q[0] <= (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hs_pipe_q[0] <= !((h_cnt_q >= H_SS) && (h_cnt_q < H_SE));
      vs_pipe_q[0] <= !((v_cnt_q >= V_SS) && (v_cnt_q < V_SE));
    end
  end

  // Stage 2: colour select and output register.
  logic [23:0] rd_data;
  logic [23:0] pix_d, pix_q;

  assign rd_data = rd_sel_q ? g_buf[1].rd_q : g_buf[0].rd_q;

  always_comb begin
    pix_d = BG_COLOR;
    if (!de_pipe_q[0]) begin
      pix_d = '0;
    end else if (img1_q) begin
      pix_d = rd_data;
      if (grid1_q && (rd_data == BG_COLOR)) pix_d = GRID_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q        <= '0;
      de_pipe_q[1] <= 1'b0;
      hs_pipe_q[1] <= 1'b1;
      vs_pipe_q[1] <= 1'b1;
    end else begin
      pix_q        <= pix_d;
      de_pipe_q[1] <= de_pipe_q[0];
      hs_pipe_q[1] <= hs_pipe_q[0];
      vs_pipe_q[1] <= vs_pipe_q[0];
    end
  end

  assign bus.pixel_rgb = pix_q;
  assign bus.de        = de_pipe_q[1];
  assign bus.hsync     = hs_pipe_q[1];
  assign bus.vsync     = vs_pipe_q[1];
endmodule

// File: tb/tb_row_scanout.sv
// Randomized scoreboard bench for row_scanout with a shortened vertical frame.
module tb_row_scanout;
  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 8, VF = 1, VS = 2, VB = 2;
  localparam int IW = 480;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [23:0] BG = 24'h000000;
  localparam int RST_T = 43 * HT + 300;   // line v=3, h=300 of the fourth frame

  typedef struct packed {
    logic [23:0] pix;
    logic        de;
    logic        hs;
    logic        vs;
  } vid_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  row_scanout_if bus();

  row_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .IMG_W(IW), .BG_COLOR(BG)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  vid_t        vq[$];
  logic        sq[$];
  bit          chk_en = 1'b0;
  int          total = 0;
  int          bad = 0;
  logic [23:0] pend [512];
  logic [23:0] shown [512];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected video for counter position (h, v), using the row currently in front.
  function automatic vid_t ref_vid(input int h, input int v);
    vid_t r;
    r.de  = (h < HA) && (v < VA);
    r.pix = 24'h0;
    if (r.de) begin
      r.pix = (h < IW) ? shown[h] : BG;
`ifdef ROW_SCANOUT_GRID_EN
      if ((h < IW) && (shown[h] == BG) && ((h % 48 == 0) || (v % 48 == 0))) r.pix = 24'h404040;
`endif
    end
    r.hs = !((h >= HA + HF) && (h < HA + HF + HS));
    r.vs = !((v >= VA + VF) && (v < VA + VF + VS));
    return r;
  endfunction

  task automatic step_model(input int t, input bit wr, input int a, input logic [23:0] d);
    int h, v;
    bit s;
    h = t % HT;
    v = (VT - 1 + t / HT) % VT;
    s = (h == HA) && ((v < VA - 1) || (v == VT - 1));
    sq.push_back(s);
    vq.push_back(ref_vid(h, v));
    if (wr) pend[a] = d;
    if (s) begin
      for (int i = 0; i < 512; i++) begin
        shown[i] = pend[i];
        pend[i]  = BG;
      end
    end
  endtask

  task automatic model_reset();
    vid_t rv;
    rv = '{pix: 24'h0, de: 1'b0, hs: 1'b1, vs: 1'b1};
    vq.delete();
    sq.delete();
    vq.push_back(rv);
    vq.push_back(rv);
    for (int i = 0; i < 512; i++) begin
      pend[i]  = BG;
      shown[i] = BG;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_de"},    32'(bus.de),        32'd0);
    check({tag, "_hsync"}, 32'(bus.hsync),     32'd1);
    check({tag, "_vsync"}, 32'(bus.vsync),     32'd1);
    check({tag, "_swap"},  32'(bus.swap),      32'd0);
    check({tag, "_pixel"}, 32'(bus.pixel_rgb), 32'd0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (sq.size() > 0) begin
        logic es;
        es = sq.pop_front();
        check("swap", 32'(bus.swap), 32'(es));
      end
      if (vq.size() >= 3) begin
        vid_t ev;
        ev = vq.pop_front();
        check("video{pix,de,hs,vs}", 32'({bus.pixel_rgb, bus.de, bus.hsync, bus.vsync}), 32'(ev));
      end
    end
  end

  task automatic run_phase(input int ncyc, input bit first);
    int first_swap, nswap, vlow;
    first_swap = -1;
    nswap = 0;
    vlow = 0;
    for (int t = 0; t < ncyc; t++) begin
      bit wr;
      int a;
      logic [23:0] d;
      if (first && t == RST_T) begin
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midline_reset");
        break;
      end
      wr = 1'b0;
      a = 0;
      d = 24'h0;
      if (first && t == 5) begin
        wr = 1'b1; a = 10; d = 24'hFF0000;
      end else if (first && t == 100) begin
        wr = 1'b1; a = 500; d = 24'h00FF00;
      end else if (first && t == HT + HA) begin
        wr = 1'b1; a = 20; d = 24'h0000FF;     // lands on the swap cycle
      end else if ((!first || (t >= 2000 && t < RST_T - 2700)) && $urandom_range(0, 3) == 0) begin
        wr = 1'b1;
        a  = int'($urandom_range(0, 511));
        d  = 24'($urandom);
      end
      bus.wren              = wr;
      bus.address_write_row = 9'(a);
      bus.data_write_row    = d;
      step_model(t, wr, a, d);
      if (bus.swap && first_swap < 0) first_swap = t;
      if (t < FRAME) begin
        if (bus.swap) nswap++;
        if (!bus.vsync) vlow++;
      end
      if (t == FRAME - 1 && first) begin
        check("swaps_per_frame", 32'(nswap), 32'(VA));
        check("vsync_low_clocks", 32'(vlow), 32'(VS * HT));
      end
      @(posedge clk);
      #1;
    end
    bus.wren = 1'b0;
    check("first_swap_clock", 32'(first_swap), 32'(HA));
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("held_reset");
    model_reset();
    rst_n  = 1'b1;
    chk_en = 1'b1;
  endtask

  initial begin
    bus.wren = 1'b0;
    bus.address_write_row = '0;
    bus.data_write_row = '0;
    #1 rst_n = 1'b0;
    release_reset();
    run_phase(RST_T + 10, 1'b1);
    release_reset();
    run_phase(FRAME + 2 * HT, 1'b0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
